// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller and its subtract-compare datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller state encoding, iteration counter width, default MAX_ITER.
package gcd_pkg;

  localparam int ITER_W = 16;

  // Default cap on subtraction cycles before the controller gives up.
  localparam logic [ITER_W-1:0] MAX_ITER_DEFAULT = 16'd65535;

  // State encoding, also decoded by the datapath bench.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_CMP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_A = ST_LOAD_A,
    S_LOAD_B = ST_LOAD_B,
    S_CMP    = ST_CMP,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } gcd_state_e;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating, clearable iteration counter for the GCD controller.
// Latency: count_o reflects clr_i/inc_i one clock after they are sampled.
// Backpressure: none; saturates at all-ones and never wraps.
// Ports: clock, reset_n (async active-low), clr_i (synchronous clear, wins
//        over inc_i), inc_i (count one cycle), count_o (current count).
module gcd_iter_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for a subtract-and-compare GCD datapath (Euclid by subtraction).
// Latency: 2 load cycles, then one subtraction per clock; done/error one clock after eq / limit.
// Backpressure: in_ready held in load states until in_valid; done/error held until ack.
// Ports: clock, reset_n (async active-low); start; in_valid/in_ready (operand
//        handshake); gt/lt/eq (datapath flags); ldA/ldB, sel1/sel2/sel_in
//        (datapath controls, combinational); ack; busy/done/error (registered
//        state decode); iter_count (subtraction cycles in current/last run).
module gcd_controller
  import gcd_pkg::*;
#(
  parameter logic [ITER_W-1:0] MAX_ITER = MAX_ITER_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ITER_W-1:0] iter_count
);

  gcd_state_e state_q;
  gcd_state_e state_d;
  logic       busy_q;
  logic       done_q;
  logic       error_q;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       at_limit;

  assign at_limit = (iter_count == MAX_ITER);

  // Next state and combinational datapath controls.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          cnt_clr = 1'b1;
        end
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ldA     = 1'b1;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ldB     = 1'b1;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        // eq wins over the limit so a run that converges on the last
        // permitted subtraction still reports a result.
        if (eq) begin
          state_d = S_DONE;
        end else if (at_limit) begin
          state_d = S_ERR;
        end else if (gt) begin
          sel1    = 1'b1;
          sel_in  = 1'b1;
          ldA     = 1'b1;
          cnt_inc = 1'b1;
        end else if (lt) begin
          sel2    = 1'b1;
          sel_in  = 1'b1;
          ldB     = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they track the
  // state register exactly while coming straight out of flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_CMP);
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERR);
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  gcd_iter_counter #(
    .W (ITER_W)
  ) u_iter_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (iter_count)
  );

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller with a behavioural subtract-compare datapath.
// Vectors come from a table; expected results are queued at start and
// popped when done/error appears. Hand sequences cover reset corners.
module tb_gcd_controller;
  import gcd_pkg::*;

  localparam logic [15:0] TB_MAX_ITER = 16'd16;
  localparam int          NVEC        = 10;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        gt, lt, eq;
  logic        ldA, ldB, sel1, sel2, sel_in;
  logic        ack;
  logic        busy, done, error;
  logic [15:0] iter_count;

  // Behavioural datapath driven by the controller.
  logic [15:0] data_in;
  logic [15:0] reg_a = 16'd0;
  logic [15:0] reg_b = 16'd0;
  logic [15:0] sub_x, sub_y, sub_res;
  logic        clr_cnt;
  int          sub_loads = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_a;
    logic [15:0] exp_iter;
    logic        exp_err;
    int          stall;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t sb_q [$];

  always #5 clock = ~clock;

  assign sub_x   = sel1 ? reg_a : reg_b;
  assign sub_y   = sel2 ? reg_a : reg_b;
  assign sub_res = sub_x - sub_y;
  assign gt      = (reg_a > reg_b);
  assign lt      = (reg_a < reg_b);
  assign eq      = (reg_a == reg_b);

  always @(posedge clock) begin
    if (ldA) reg_a <= sel_in ? sub_res : data_in;
    if (ldB) reg_b <= sel_in ? sub_res : data_in;
  end

  always @(posedge clock) begin
    if (clr_cnt) sub_loads <= 0;
    else if ((ldA || ldB) && sel_in) sub_loads <= sub_loads + 1;
  end

  gcd_controller #(
    .MAX_ITER (TB_MAX_ITER)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gt         (gt),
    .lt         (lt),
    .eq         (eq),
    .ldA        (ldA),
    .ldB        (ldB),
    .sel1       (sel1),
    .sel2       (sel2),
    .sel_in     (sel_in),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .iter_count (iter_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, error, iter_count};
  endfunction

  // Full run from IDLE; entered and left on a falling edge.
  task automatic run_vec(input vec_t v);
    vec_t exp;
    int   cyc;
    sb_q.push_back(v);
    start   = 1'b1;
    clr_cnt = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    clr_cnt = 1'b0;
    chk("iter_cleared_on_start", iter_count, 0);
    chk("busy_in_load_a", busy, 1);
    for (int i = 0; i < v.stall; i++) begin
      in_valid = 1'b0;
      start    = 1'b1;               // must be ignored while busy
      #1;
      chk("stall_in_ready", in_ready, 1);
      chk("stall_no_ldA", ldA, 0);
      @(negedge clock);
    end
    start    = 1'b0;
    data_in  = v.a;
    in_valid = 1'b1;
    #1;
    chk("load_a_ctrl", {ldA, ldB, sel_in, in_ready}, 4'b1001);
    @(negedge clock);
    data_in = v.b;
    #1;
    chk("load_b_ctrl", {ldA, ldB, sel_in, in_ready}, 4'b0101);
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 0;
    while (!(done || error) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 200) begin
      chk("timeout_waiting_done", 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    exp = sb_q.pop_front();
    chk("done_flag", done, !exp.exp_err);
    chk("error_flag", error, exp.exp_err);
    chk("iter_count", iter_count, exp.exp_iter);
    chk("cmp_cycles", cyc, exp.exp_iter + 1);
    chk("sub_load_pulses", sub_loads, exp.exp_iter);
    chk("busy_at_end", busy, 0);
    if (!exp.exp_err) chk("gcd_result", reg_a, exp.exp_a);
    // start without ack must not leave DONE/ERR
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_ignored_at_end", {busy, done, error}, {1'b0, !exp.exp_err, exp.exp_err});
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk("idle_after_ack", {in_ready, busy, done, error}, 4'b0000);
    chk("iter_held_in_idle", iter_count, exp.exp_iter);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a_at_rst;
    vec_t        v;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    ack      = 1'b0;
    data_in  = 16'd0;
    clr_cnt  = 1'b0;

    //            a     b     exp_a exp_iter err stall
    vecs[0] = '{16'd12,  16'd8,   16'd4,   16'd2,  1'b0, 0};
    vecs[1] = '{16'd143, 16'd143, 16'd143, 16'd0,  1'b0, 0};
    vecs[2] = '{16'd21,  16'd6,   16'd3,   16'd4,  1'b0, 0};
    vecs[3] = '{16'd9,   16'd12,  16'd3,   16'd3,  1'b0, 5};
    vecs[4] = '{16'd17,  16'd5,   16'd1,   16'd6,  1'b0, 0};
    vecs[5] = '{16'd16,  16'd1,   16'd1,   16'd15, 1'b0, 0};
    vecs[6] = '{16'd17,  16'd1,   16'd1,   16'd16, 1'b0, 0};
    vecs[7] = '{16'd18,  16'd1,   16'd0,   16'd16, 1'b1, 0};
    vecs[8] = '{16'd7,   16'd0,   16'd0,   16'd16, 1'b1, 0};
    vecs[9] = '{16'd0,   16'd5,   16'd0,   16'd16, 1'b1, 0};

    // Reset state, before any clock edge.
    #3;
    chk("reset_outputs", all_outs(), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_after_reset", all_outs(), 0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
    end

    // Reset pulsed mid-computation with A=100, B=3.
    start = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    data_in  = 16'd100;
    in_valid = 1'b1;
    @(negedge clock);
    data_in = 16'd3;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk("midrun_iter", iter_count, 4);
    chk("midrun_ldA", {ldA, sel1, sel_in}, 3'b111);
    #2;
    reset_n  = 1'b0;
    a_at_rst = reg_a;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clock);
    chk("no_load_after_reset", reg_a, a_at_rst);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("waits_for_start", all_outs(), 0);

    // A normal run still works after the abort.
    v = '{16'd100, 16'd3, 16'd1, 16'd0, 1'b0, 0};
    // 100,3: A steps 97..1 (33 subs), then B 3->2->1 (2 subs) -> exceeds 16.
    v.exp_err  = 1'b1;
    v.exp_iter = 16'd16;
    run_vec(v);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
